// File: rtl/mesh_router_vc.sv
// Five-port mesh router node: per-input FIFOs, X-then-Y routing, per-output
// round-robin arbitration with a registered output stage and optional VC gating.
module mesh_router_vc #(
  parameter int DATA_W  = 64,
  parameter int HOP_W   = 4,
  parameter int DEPTH   = 4,
  parameter int VC_GATE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  polarity_out,
  input  logic [4:0]            in_send,
  input  logic [5*DATA_W-1:0]   in_data,
  output logic [4:0]            in_ready,
  output logic [4:0]            out_send,
  output logic [5*DATA_W-1:0]   out_data,
  input  logic [4:0]            out_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int X_MSB = DATA_W - 13;
  localparam int Y_MSB = DATA_W - 9;

  localparam logic [2:0] P_PE  = 3'd0;
  localparam logic [2:0] P_CW  = 3'd1;
  localparam logic [2:0] P_CCW = 3'd2;
  localparam logic [2:0] P_NS  = 3'd3;
  localparam logic [2:0] P_SN  = 3'd4;

  logic [DATA_W-1:0] mem_r      [5][DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r   [5];
  logic [PTR_W-1:0]  wr_ptr_r   [5];
  logic [CNT_W-1:0]  count_r    [5];
  logic [2:0]        rr_ptr_r   [5];
  logic              polarity_r;

  logic [DATA_W-1:0] head_s     [5];
  logic [DATA_W-1:0] mod_s      [5];
  logic [2:0]        route_s    [5];
  logic [2:0]        winner_s   [5];
  logic [4:0]        head_valid_s;
  logic [4:0]        eligible_s;
  logic [4:0]        full_s;
  logic [4:0]        push_s;
  logic [4:0]        pop_s;
  logic [4:0]        grant_s;
  logic [4:0]        stage_free_s;

  function automatic logic [2:0] mod5_add(input logic [2:0] base, input logic [2:0] off);
    logic [3:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    return (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
  endfunction

  assign polarity_out = polarity_r;

  // Head decode: occupancy, route selection and departure header per input.
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      head_s[p]       = mem_r[p][rd_ptr_r[p]];
      head_valid_s[p] = (count_r[p] != {CNT_W{1'b0}});
      full_s[p]       = (count_r[p] == CNT_W'(DEPTH));
      in_ready[p]     = !full_s[p] && !reset;
      push_s[p]       = in_send[p] && in_ready[p];
      if (head_s[p][X_MSB -: HOP_W] != {HOP_W{1'b0}}) begin
        route_s[p] = head_s[p][DATA_W-3] ? P_CW : P_CCW;
      end else if (head_s[p][Y_MSB -: HOP_W] != {HOP_W{1'b0}}) begin
        route_s[p] = head_s[p][DATA_W-2] ? P_SN : P_NS;
      end else begin
        route_s[p] = P_PE;
      end
      mod_s[p] = head_s[p];
      case (route_s[p])
        P_CW, P_CCW: mod_s[p][X_MSB -: HOP_W] = head_s[p][X_MSB -: HOP_W] - HOP_W'(1);
        P_NS, P_SN:  mod_s[p][Y_MSB -: HOP_W] = head_s[p][Y_MSB -: HOP_W] - HOP_W'(1);
        default:     mod_s[p] = head_s[p];
      endcase
      eligible_s[p] = head_valid_s[p] &&
                      ((VC_GATE == 0) || (head_s[p][DATA_W-1] == polarity_r));
    end
  end

  // Round-robin search from each output's pointer; a granted head pops only if the stage is free.
  always_comb begin
    pop_s = 5'b00000;
    for (int o = 0; o < 5; o++) begin
      grant_s[o]      = 1'b0;
      winner_s[o]     = 3'd0;
      stage_free_s[o] = !out_send[o] || out_ready[o];
      for (int i = 0; i < 5; i++) begin
        if (!grant_s[o] && eligible_s[mod5_add(rr_ptr_r[o], 3'(i))] &&
            (route_s[mod5_add(rr_ptr_r[o], 3'(i))] == 3'(o))) begin
          grant_s[o]  = 1'b1;
          winner_s[o] = mod5_add(rr_ptr_r[o], 3'(i));
        end else begin
          grant_s[o]  = grant_s[o];
        end
      end
      if (grant_s[o] && stage_free_s[o]) begin
        pop_s[winner_s[o]] = 1'b1;
      end else begin
        pop_s = pop_s;
      end
    end
  end

  // FIFO storage: written on accepted pushes, never reset (occupancy tracks validity).
  always_ff @(posedge clk) begin
    for (int p = 0; p < 5; p++) begin
      if (push_s[p]) begin
        mem_r[p][wr_ptr_r[p]] <= in_data[p*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 5; p++) begin
        rd_ptr_r[p] <= {PTR_W{1'b0}};
        wr_ptr_r[p] <= {PTR_W{1'b0}};
        count_r[p]  <= {CNT_W{1'b0}};
      end
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (push_s[p]) wr_ptr_r[p] <= ptr_inc(wr_ptr_r[p]);
        if (pop_s[p])  rd_ptr_r[p] <= ptr_inc(rd_ptr_r[p]);
        case ({push_s[p], pop_s[p]})
          2'b10:   count_r[p] <= count_r[p] + CNT_W'(1);
          2'b01:   count_r[p] <= count_r[p] - CNT_W'(1);
          default: count_r[p] <= count_r[p];
        endcase
      end
    end
  end

  // Output stages, round-robin pointers and the free-running VC polarity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      polarity_r <= 1'b0;
      out_send   <= 5'b00000;
      out_data   <= {(5*DATA_W){1'b0}};
      for (int o = 0; o < 5; o++) begin
        rr_ptr_r[o] <= 3'd0;
      end
    end else begin
      polarity_r <= !polarity_r;
      for (int o = 0; o < 5; o++) begin
        if (stage_free_s[o]) begin
          if (grant_s[o]) begin
            out_data[o*DATA_W +: DATA_W] <= mod_s[winner_s[o]];
            out_send[o]                  <= 1'b1;
            rr_ptr_r[o]                  <= mod5_add(winner_s[o], 3'd1);
          end else begin
            out_send[o] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mesh_router_vc.sv
// Directed bench for mesh_router_vc: a vector table of single-flit routes plus
// hand-written reset, contention, backpressure and VC-gating sequences.
module tb_mesh_router_vc;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           polarity_out, g_polarity_out;
  logic [4:0]     in_send, in_ready, out_send, out_ready;
  logic [4:0]     g_in_send, g_in_ready, g_out_send, g_out_ready;
  logic [5*W-1:0] in_data, out_data, g_in_data, g_out_data;

  int total = 0;
  int bad = 0;

  mesh_router_vc #(.DATA_W(W), .HOP_W(4), .DEPTH(4), .VC_GATE(0)) dut (
    .clk(clk), .reset(reset), .polarity_out(polarity_out),
    .in_send(in_send), .in_data(in_data), .in_ready(in_ready),
    .out_send(out_send), .out_data(out_data), .out_ready(out_ready));

  mesh_router_vc #(.DATA_W(W), .HOP_W(4), .DEPTH(4), .VC_GATE(1)) gdut (
    .clk(clk), .reset(reset), .polarity_out(g_polarity_out),
    .in_send(g_in_send), .in_data(g_in_data), .in_ready(g_in_ready),
    .out_send(g_out_send), .out_data(g_out_data), .out_ready(g_out_ready));

  always #5 clk = ~clk;

  typedef struct {
    int          in_port;
    logic [63:0] flit;
    int          out_port;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[9];
  logic [63:0] exp_q[6];

  function automatic logic [63:0] mk(input logic vc, input logic ns, input logic ew,
                                     input logic [3:0] y, input logic [3:0] x,
                                     input logic [31:0] pl);
    return {vc, ns, ew, 5'b00000, y, x, 16'hA5A5, pl};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, mk(1'b0, 1'b0, 1'b1, 4'd2, 4'd3, 32'hDEADBEEF), 1, mk(1'b0, 1'b0, 1'b1, 4'd2, 4'd2, 32'hDEADBEEF)};
    vecs[1] = '{1, mk(1'b0, 1'b0, 1'b0, 4'd2, 4'd0, 32'h12345678), 3, mk(1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 32'h12345678)};
    vecs[2] = '{1, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'hCAFEF00D), 0, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'hCAFEF00D)};
    vecs[3] = '{2, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 32'h0BADC0DE), 2, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0BADC0DE)};
    vecs[4] = '{3, mk(1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 32'h31415926), 4, mk(1'b0, 1'b1, 1'b0, 4'd2, 4'd0, 32'h31415926)};
    vecs[5] = '{4, mk(1'b0, 1'b1, 1'b1, 4'd1, 4'd2, 32'h27182818), 1, mk(1'b0, 1'b1, 1'b1, 4'd1, 4'd1, 32'h27182818)};
    vecs[6] = '{0, mk(1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 32'hAAAA5555), 3, mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 32'hAAAA5555)};
    vecs[7] = '{0, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd15, 32'hFFFF0000), 2, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd14, 32'hFFFF0000)};
    vecs[8] = '{3, mk(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 32'h76543210), 0, mk(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 32'h76543210)};

    in_send = 5'b00000;   in_data = '0;   out_ready = 5'b11111;
    g_in_send = 5'b00000; g_in_data = '0; g_out_ready = 5'b11111;

    // Power-on reset state
    #1;
    check("por_out_send", 64'(out_send), 64'd0);
    check("por_polarity", 64'(polarity_out), 64'd0);
    check("por_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'h1F);
    check("rel_g_in_ready", 64'(g_in_ready), 64'h1F);
    @(negedge clk);
    check("pol_after_1", 64'(polarity_out), 64'd1);
    @(negedge clk);
    check("pol_after_2", 64'(polarity_out), 64'd0);

    // Table: one flit per vector, two-edge latency
    for (int i = 0; i < 9; i++) begin
      in_data = '0;
      in_data[vecs[i].in_port*W +: W] = vecs[i].flit;
      in_send = 5'b00001 << vecs[i].in_port;
      @(negedge clk);
      in_send = 5'b00000;
      check($sformatf("vec%0d_latency", i), 64'(out_send), 64'd0);
      @(negedge clk);
      check($sformatf("vec%0d_send", i), 64'(out_send), 64'(5'b00001 << vecs[i].out_port));
      check($sformatf("vec%0d_data", i), out_data[vecs[i].out_port*W +: W], vecs[i].exp_data);
    end
    @(negedge clk);

    // Reset in the middle of traffic
    out_ready = 5'b11110;
    for (int k = 0; k < 3; k++) begin
      in_data = '0;
      in_data[0*W +: W] = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'h11110000 + 32'(k));
      in_data[1*W +: W] = mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 32'h22220000 + 32'(k));
      in_send = 5'b00011;
      @(negedge clk);
    end
    check("pre_rst_busy", 64'(out_send), 64'h3);
    in_send = 5'b00000;
    #2 reset = 1'b1;
    #1;
    check("rst_out_send", 64'(out_send), 64'd0);
    check("rst_out_data", 64'(|out_data), 64'd0);
    check("rst_polarity", 64'(polarity_out), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 5'b11111;
    #1;
    check("rst_rel_in_ready", 64'(in_ready), 64'h1F);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rst_no_stale%0d", k), 64'(out_send), 64'd0);
    end

    // Contention: inputs 0 and 2 both to CW, pointer 0 after reset
    for (int k = 0; k < 3; k++) begin
      exp_q[2*k]     = mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 32'hA0000000 + 32'(k));
      exp_q[2*k + 1] = mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 32'hC0000000 + 32'(k));
    end
    for (int c = 0; c < 9; c++) begin
      if (c < 3) begin
        in_data = '0;
        in_data[0*W +: W] = mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 32'hA0000000 + 32'(c));
        in_data[2*W +: W] = mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 32'hC0000000 + 32'(c));
        in_send = 5'b00101;
      end else begin
        in_send = 5'b00000;
      end
      if (c >= 2 && c < 8) begin
        check($sformatf("rr_send%0d", c - 2), 64'(out_send), 64'h2);
        check($sformatf("rr_data%0d", c - 2), out_data[1*W +: W], exp_q[c - 2]);
      end else if (c == 8) begin
        check("rr_drained", 64'(out_send), 64'd0);
      end
      @(negedge clk);
    end

    // Backpressure on output 4 with six SN flits from input 4
    out_ready = 5'b01111;
    for (int c = 0; c < 6; c++) begin
      in_data = '0;
      in_data[4*W +: W] = mk(1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 32'hB0000000 + 32'(c));
      in_send = 5'b10000;
      if (c == 5) check("bp_full_ready", 64'(in_ready[4]), 64'd0);
      @(negedge clk);
    end
    in_send = 5'b00000;
    check("bp_refused_ready", 64'(in_ready[4]), 64'd0);
    check("bp_held_send", 64'(out_send), 64'h10);
    check("bp_held_data", out_data[4*W +: W], mk(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 32'hB0000000));
    out_ready = 5'b11111;
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      if (c == 1) check("bp_ready_back", 64'(in_ready[4]), 64'd1);
      check($sformatf("bp_send%0d", c), 64'(out_send), 64'h10);
      check($sformatf("bp_data%0d", c), out_data[4*W +: W],
            mk(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 32'hB0000000 + 32'(c)));
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("bp_no_sixth%0d", c), 64'(out_send), 64'd0);
    end

    // VC gating: a VC=1 head waits for polarity 1
    if (g_polarity_out == 1'b0) @(negedge clk);
    g_in_data = '0;
    g_in_data[0*W +: W] = mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'h5C5C5C5C);
    g_in_send = 5'b00001;
    @(negedge clk);
    g_in_send = 5'b00000;
    check("vc_wait_pol", 64'(g_polarity_out), 64'd0);
    check("vc_wait_send0", 64'(g_out_send), 64'd0);
    @(negedge clk);
    check("vc_wait_pol1", 64'(g_polarity_out), 64'd1);
    check("vc_wait_send1", 64'(g_out_send), 64'd0);
    @(negedge clk);
    check("vc_grant_send", 64'(g_out_send), 64'h1);
    check("vc_grant_data", g_out_data[0*W +: W], mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'h5C5C5C5C));
    // Polarity is 0 now, so the flit written next edge sees polarity 1 and goes at once
    g_in_data[0*W +: W] = mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'h6D6D6D6D);
    g_in_send = 5'b00001;
    @(negedge clk);
    g_in_send = 5'b00000;
    check("vc_fast_latency", 64'(g_out_send), 64'd0);
    @(negedge clk);
    check("vc_fast_send", 64'(g_out_send), 64'h1);
    check("vc_fast_data", g_out_data[0*W +: W], mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'h6D6D6D6D));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
